// File: rtl/b2b_pkg.sv
// ============================================================================
// b2b_pkg : shared types and helpers for the board-to-board link stages
// Rev 1.0
// ============================================================================
`default_nettype none

package b2b_pkg;

  localparam int B2B_DATA_WIDTH = 65;
  localparam int META_BIT       = B2B_DATA_WIDTH - 1;

  typedef enum logic {
    OUT_OF_EVENT = 1'b0,
    IN_EVENT     = 1'b1
  } frame_state_t;

  function automatic logic is_meta(input logic [B2B_DATA_WIDTH-1:0] word);
    return word[META_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/b2b_skid_fifo2.sv
// ============================================================================
// b2b_skid_fifo2 : 2-entry registered FIFO, head word always in head_data
// Rev 1.0
// ============================================================================
`default_nettype none

module b2b_skid_fifo2 #(
  parameter int WIDTH = 66
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] slot1;

  // Callers never pop when empty nor push when full without a pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy <= 2'd0;
      head_data <= '0;
      slot1     <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) head_data <= push_data;
          else                   slot1     <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head_data <= slot1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= slot1;
            slot1     <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/b2b_board_link_tx.sv
// ============================================================================
// b2b_board_link_tx : drains a SpyBuffer FIFO, checks event framing, drives link
// Optional stats outputs with B2B_BOARD_LINK_TX_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module b2b_board_link_tx
  import b2b_pkg::*;
#(
  parameter int DATA_WIDTH      = 65,
  parameter int MAX_EVENT_WORDS = 1024,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic                  link_valid,
  input  logic                  link_ready,
  output logic                  link_idle,
  output logic [CNT_WIDTH-1:0]  event_count,
  output logic                  framing_error
`ifdef B2B_BOARD_LINK_TX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  orphan_count,
  output logic [CNT_WIDTH-1:0]  overlength_count,
  output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

  localparam int BODY_CNT_W = $clog2(MAX_EVENT_WORDS + 1);
  localparam logic [BODY_CNT_W-1:0] BODY_MAX = BODY_CNT_W'(MAX_EVENT_WORDS);

  frame_state_t            state;
  logic [BODY_CNT_W-1:0]   body_cnt;
  logic                    inflight;
  logic                    meta;
  logic                    pop;
  logic                    push;
  logic                    orphan;
  logic                    overlength;
  logic                    is_footer_in;
  logic [1:0]              occupancy;
  logic [2:0]              committed;
  logic [DATA_WIDTH:0]     head;

  if (DATA_WIDTH == B2B_DATA_WIDTH) begin : g_meta_pkg
    assign meta = is_meta(fifo_read_data);
  end else begin : g_meta_bit
    assign meta = fifo_read_data[DATA_WIDTH-1];
  end

  assign pop        = link_valid & link_ready;
  // Slots already owed: buffered words plus the word returning this cycle.
  assign committed  = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_read_enable = !fifo_empty && !reset && (committed < 3'd2);

  assign orphan       = inflight && (state == OUT_OF_EVENT) && !meta;
  assign overlength   = inflight && (state == IN_EVENT) && !meta && (body_cnt == BODY_MAX);
  assign push         = inflight && !orphan && !overlength;
  assign is_footer_in = (state == IN_EVENT) && meta;

  // Footer tag rides alongside the word so counting happens on pop.
  b2b_skid_fifo2 #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({is_footer_in, fifo_read_data}),
    .pop       (pop),
    .occupancy (occupancy),
    .head_data (head)
  );

  assign link_valid = (occupancy != 2'd0);
  assign link_data  = head[DATA_WIDTH-1:0];
  assign link_idle  = (state == OUT_OF_EVENT) && (occupancy == 2'd0) && !inflight;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= OUT_OF_EVENT;
      body_cnt      <= '0;
      inflight      <= 1'b0;
      event_count   <= '0;
      framing_error <= 1'b0;
    end else begin
      inflight      <= fifo_read_enable;
      framing_error <= orphan | overlength;
      if (pop && head[DATA_WIDTH]) event_count <= event_count + CNT_WIDTH'(1);
      if (inflight) begin
        case (state)
          OUT_OF_EVENT: begin
            if (meta) begin
              state    <= IN_EVENT;
              body_cnt <= '0;
            end
          end
          IN_EVENT: begin
            if (meta)             state    <= OUT_OF_EVENT;
            else if (!overlength) body_cnt <= body_cnt + BODY_CNT_W'(1);
          end
          default: state <= OUT_OF_EVENT;
        endcase
      end
    end
  end

`ifdef B2B_BOARD_LINK_TX_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      orphan_count     <= '0;
      overlength_count <= '0;
      stall_count      <= '0;
    end else begin
      if (orphan && (orphan_count != '1))
        orphan_count <= orphan_count + CNT_WIDTH'(1);
      if (overlength && (overlength_count != '1))
        overlength_count <= overlength_count + CNT_WIDTH'(1);
      if (link_valid && !link_ready && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_b2b_board_link_tx.sv
// ============================================================================
// tb_b2b_board_link_tx : directed + randomized bench with an event-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_b2b_board_link_tx;
  import b2b_pkg::*;

  localparam int DW   = 65;
  localparam int MAXW = 4;
  localparam int CW   = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data = '0;
  logic [DW-1:0] link_data;
  logic          link_valid;
  logic          link_ready = 1'b0;
  logic          link_idle;
  logic [CW-1:0] event_count;
  logic          framing_error;
`ifdef B2B_BOARD_LINK_TX_STATS_EN
  logic [CW-1:0] orphan_count, overlength_count, stall_count;
`endif

  b2b_board_link_tx #(.DATA_WIDTH(DW), .MAX_EVENT_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .link_data        (link_data),
    .link_valid       (link_valid),
    .link_ready       (link_ready),
    .link_idle        (link_idle),
    .event_count      (event_count),
    .framing_error    (framing_error)
`ifdef B2B_BOARD_LINK_TX_STATS_EN
    ,
    .orphan_count     (orphan_count),
    .overlength_count (overlength_count),
    .stall_count      (stall_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed { logic footer; logic [DW-1:0] word; } exp_t;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] obs_q[$];
  exp_t          exp_q[$];
  int checks = 0, failures = 0;
  bit m_in_event = 0;
  int m_body = 0, m_err = 0, m_events = 0, m_stall = 0, m_orphan = 0, m_overlen = 0;
  int seen_err = 0, n_pop = 0, n_reads = 0, run = 0, max_run = 0;
  int cyc = 0, first_rd_cyc = -1, first_vld_cyc = -1;
  int ready_mode = 0, pat = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] rd_word;
  exp_t          head_exp;

  function automatic logic [DW-1:0] mk(input bit meta, input logic [63:0] p);
    return {meta, p};
  endfunction

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Event-level framing rules applied to each word in read order.
  function automatic void classify(input logic [DW-1:0] w);
    if (!m_in_event) begin
      if (w[DW-1]) begin m_in_event = 1; m_body = 0; exp_q.push_back({1'b0, w}); end
      else begin m_err++; m_orphan++; end
    end else if (w[DW-1]) begin
      m_in_event = 0;
      exp_q.push_back({1'b1, w});
    end else if (m_body == MAXW) begin
      m_err++; m_overlen++;
    end else begin
      m_body++;
      exp_q.push_back({1'b0, w});
    end
  endfunction

  // Upstream FIFO with one-cycle read latency, plus model update on each read.
  always @(posedge clock) begin
    if (fifo_read_enable && first_rd_cyc < 0) first_rd_cyc = cyc;
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_in_event = 0; m_body = 0; m_err = 0; m_events = 0;
      m_stall = 0; m_orphan = 0; m_overlen = 0;
    end else if (fifo_read_enable) begin
      if (src_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_when_empty actual=1 required=0");
      end else begin
        rd_word = src_q.pop_front();
        fifo_read_data <= rd_word;
        n_reads++;
        classify(rd_word);
      end
    end
    fifo_empty <= (src_q.size() == 0);
  end

  always @(posedge clock) begin
    #1;
    pat++;
    case (ready_mode)
      0:       link_ready = 1'b1;
      1:       link_ready = (pat % 3 == 0);
      default: link_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Single compare process: every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      chk("event_count", DW'(event_count), DW'(m_events));
`ifdef B2B_BOARD_LINK_TX_STATS_EN
      chk("stall_count", DW'(stall_count), DW'(m_stall));
`endif
      if (prev_stall) begin
        chk("stall_valid_hold", DW'(link_valid), DW'(1));
        chk("stall_data_hold", link_data, prev_data);
      end
      chk("outstanding_le2", DW'(exp_q.size() <= 2), DW'(1));
      if (m_in_event || exp_q.size() != 0) chk("idle_while_busy", DW'(link_idle), DW'(0));
      if (link_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (link_ready) begin
          n_pop++;
          obs_q.push_back(link_data);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word actual=%0h required=none", link_data);
          end else begin
            head_exp = exp_q.pop_front();
            chk("link_data", link_data, head_exp.word);
            if (head_exp.footer) m_events++;
          end
        end else begin
          m_stall++;
        end
      end else begin
        run = 0;
      end
      prev_stall = link_valid && !link_ready;
      prev_data  = link_data;
      if (framing_error) seen_err++;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_q.delete();
    fifo_empty = 1'b1;
    tick();
    reset = 1'b0;
    obs_q.delete();
    seen_err = 0; n_pop = 0; n_reads = 0; run = 0; max_run = 0;
    first_rd_cyc = -1; first_vld_cyc = -1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_link_valid"}, DW'(link_valid), DW'(0));
    chk({tag, "_link_data"}, link_data, '0);
    chk({tag, "_event_count"}, DW'(event_count), DW'(0));
    chk({tag, "_link_idle"}, DW'(link_idle), DW'(1));
    chk({tag, "_framing_error"}, DW'(framing_error), DW'(0));
`ifdef B2B_BOARD_LINK_TX_STATS_EN
    chk({tag, "_orphan_count"}, DW'(orphan_count), DW'(0));
    chk({tag, "_overlength_count"}, DW'(overlength_count), DW'(0));
    chk({tag, "_stall_count"}, DW'(stall_count), DW'(0));
`endif
  endtask

  task automatic src_push(input logic [DW-1:0] w);
    src_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && link_idle) && t < 400) begin
      tick(); t++;
    end
    if (t >= 400) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=<400", t);
    end
    tick(3);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_framing_errors"}, DW'(seen_err), DW'(m_err));
    chk({tag, "_link_idle_end"}, DW'(link_idle), DW'(1));
`ifdef B2B_BOARD_LINK_TX_STATS_EN
    chk({tag, "_orphan_count"}, DW'(orphan_count), DW'(m_orphan));
    chk({tag, "_overlength_count"}, DW'(overlength_count), DW'(m_overlen));
`endif
  endtask

  task automatic push_event(input int nbody, input logic [63:0] base);
    src_push(mk(1, 64'h1AA));
    for (int b = 0; b < nbody; b++) src_push(mk(0, base + 64'(b)));
    src_push(mk(1, 64'h1FF));
  endtask

  logic [DW-1:0] nom[6];
  int nev, nb, t;

  initial begin
    nom[0] = mk(1, 64'h1AA); nom[1] = mk(0, 64'h01); nom[2] = mk(0, 64'h02);
    nom[3] = mk(0, 64'h03);  nom[4] = mk(0, 64'h04); nom[5] = mk(1, 64'h1FF);

    tick(2);
    do_reset();
    reset_checks("reset");

    // Nominal event, full-rate link
    ready_mode = 0;
    push_event(4, 64'h01);
    drain();
    end_checks("nominal");
    chk("nominal_events", DW'(event_count), DW'(1));
    chk("nominal_errors", DW'(seen_err), DW'(0));
    chk("nominal_latency", DW'(first_vld_cyc - first_rd_cyc), DW'(2));
    chk("nominal_run", DW'(max_run), DW'(6));
    chk("nominal_len", DW'(obs_q.size()), DW'(6));
    for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("nominal_word", obs_q[i], nom[i]);

    // Backpressure
    do_reset();
    ready_mode = 1;
    push_event(4, 64'h01);
    drain();
    end_checks("backpressure");
    chk("bp_events", DW'(event_count), DW'(1));
    chk("bp_len", DW'(obs_q.size()), DW'(6));
    for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("bp_word", obs_q[i], nom[i]);

    // Orphan before a 3-word event
    do_reset();
    ready_mode = 0;
    src_push(mk(0, 64'h55));
    push_event(1, 64'h01);
    drain();
    end_checks("orphan");
    chk("orphan_errors", DW'(seen_err), DW'(1));
    chk("orphan_events", DW'(event_count), DW'(1));
    chk("orphan_len", DW'(obs_q.size()), DW'(3));
    if (obs_q.size() == 3) begin
      chk("orphan_w0", obs_q[0], nom[0]);
      chk("orphan_w1", obs_q[1], nom[1]);
      chk("orphan_w2", obs_q[2], nom[5]);
    end

    // Overlength: 6 body words, limit 4
    do_reset();
    ready_mode = 2;
    push_event(6, 64'h01);
    drain();
    end_checks("overlength");
    chk("ovl_errors", DW'(seen_err), DW'(2));
    chk("ovl_events", DW'(event_count), DW'(1));
    chk("ovl_len", DW'(obs_q.size()), DW'(6));
    for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("ovl_word", obs_q[i], nom[i]);

    // Reset mid-event after H and B0 have been read
    do_reset();
    ready_mode = 0;
    push_event(3, 64'h01);
    t = 0;
    while (n_reads < 2 && t < 50) begin tick(); t++; end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL midreset_wait actual=%0d required=2", n_reads);
    end
    do_reset();
    reset_checks("midreset");
    chk("midreset_no_read", DW'(fifo_read_enable), DW'(0));
    push_event(1, 64'h01);
    drain();
    end_checks("midreset");
    chk("midreset_events", DW'(event_count), DW'(1));
    chk("midreset_len", DW'(obs_q.size()), DW'(3));

    // Back-to-back events
    do_reset();
    ready_mode = 0;
    push_event(1, 64'h01);
    push_event(1, 64'h02);
    t = 0;
    while (first_vld_cyc < 0 && t < 20) begin tick(); t++; end
    while (n_pop < 6 && t < 60) begin
      chk("b2b_not_idle", DW'(link_idle), DW'(0));
      tick(); t++;
    end
    drain();
    end_checks("b2b");
    chk("b2b_events", DW'(event_count), DW'(2));
    chk("b2b_run", DW'(max_run), DW'(6));

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 20; it++) begin
      ready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) src_push(mk(0, 64'h55 + 64'(it)));
      nev = $urandom_range(1, 3);
      for (int e = 0; e < nev; e++) begin
        nb = $urandom_range(0, 6);
        src_push(mk(1, {32'hA, 32'($urandom)}));
        for (int b = 0; b < nb; b++) src_push(mk(0, {32'($urandom), 32'($urandom)}));
        src_push(mk(1, {32'hF, 32'($urandom)}));
      end
      drain();
      end_checks("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
